// File: rtl/scoreboard.sv
// Register scoreboard: per-register remaining-latency counters with a same-cycle hazard stall.
// Build option: define SCOREBOARD_FWD_EN to treat a source as ready one cycle before writeback.
module scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_BITS = 5,
    parameter int LAT_BITS = 3,
    parameter int CNT_BITS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [REG_BITS-1:0] issue_src_1,
    input  logic [REG_BITS-1:0] issue_src_2,
    input  logic                issue_uses_src_2,
    input  logic [REG_BITS-1:0] issue_dst,
    input  logic [LAT_BITS-1:0] issue_latency,
    input  logic                hold,
    input  logic                flush,
    output logic                hazard_stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_BITS-1:0] stall_cycles
);

    localparam int DEPTH = 2 ** REG_BITS;

`ifdef SCOREBOARD_FWD_EN
    localparam logic [LAT_BITS-1:0] READY_T = LAT_BITS'(1);
`else
    localparam logic [LAT_BITS-1:0] READY_T = '0;
`endif

    // Handshake: issue_valid is the request and hazard_stall the inverse of ready. The
    // instruction issues on a rising edge where issue_valid && !flush && !hold && !hazard_stall;
    // decode holds the instruction stable otherwise.
    logic [LAT_BITS-1:0] cnt [DEPTH];
    logic                src_1_busy;
    logic                src_2_busy;
    logic                waw;
    logic                accept;
    logic                do_mark;

    always_comb begin
        src_1_busy   = (issue_src_1 != '0) && (cnt[issue_src_1] > READY_T);
        src_2_busy   = (issue_src_2 != '0) && (cnt[issue_src_2] > READY_T);
        // A younger write must land strictly after any older write to the same register.
        waw          = (issue_latency != '0) && (issue_dst != '0) && (cnt[issue_dst] >= issue_latency);
        hazard_stall = issue_valid && !flush &&
                       (src_1_busy || (issue_uses_src_2 && src_2_busy) || waw);
        accept       = issue_valid && !flush && !hold && !hazard_stall;
        do_mark      = accept && (issue_latency != '0) && (issue_dst != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= '0;
            end
            stall_cycles <= '0;
        end else if (!hold) begin
            for (int r = 0; r < DEPTH; r++) begin
                // Register 0 and indices beyond NUM_REGS are never tracked.
                if (r == 0 || r >= NUM_REGS) begin
                    cnt[r] <= '0;
                end else if (do_mark && issue_dst == REG_BITS'(r)) begin
                    cnt[r] <= issue_latency;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_BITS'(1);
                end
            end
            if (hazard_stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

endmodule
